// File: rtl/labft_recovery_ctrl_if.sv
// Handshake bundle between the LABFT recovery controller, the error
// detector that feeds it and the tile scheduler that owns retries.
interface labft_recovery_ctrl_if #(
    parameter int maxRetries   = 2,
    parameter int tileIdWidth  = 8,
    parameter int counterWidth = 16,
    parameter int retryWidth   = $clog2(maxRetries + 1)
);
    logic                    start;
    logic [tileIdWidth-1:0]  tile_id;
    logic                    tile_done;
    logic [3:0]              error;
    logic                    retry_ack;
    logic                    fatal_clear;
    logic                    interrupt;
    logic                    tile_ok;
    logic                    retry_req;
    logic [tileIdWidth-1:0]  retry_tile;
    logic                    fatal;
    logic [3:0]              err_syndrome;
    logic [counterWidth-1:0] err_count;
    logic [retryWidth-1:0]   attempt;
    logic                    busy;

    modport master (
        output start, tile_id, tile_done, error, retry_ack, fatal_clear,
        input  interrupt, tile_ok, retry_req, retry_tile, fatal,
        input  err_syndrome, err_count, attempt, busy
    );

    modport slave (
        input  start, tile_id, tile_done, error, retry_ack, fatal_clear,
        output interrupt, tile_ok, retry_req, retry_tile, fatal,
        output err_syndrome, err_count, attempt, busy
    );
endinterface

// File: rtl/labft_recovery_ctrl.sv
// LABFT recovery controller: commits, re-issues or fails a tile based on
// the detector's final error vector; every output is a register.
module labft_recovery_ctrl #(
    parameter int maxRetries   = 2,
    parameter int tileIdWidth  = 8,
    parameter int counterWidth = 16,
    parameter int retryWidth   = $clog2(maxRetries + 1)
) (
    input logic                  clk,
    input logic                  rst,
    labft_recovery_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        RETRY = 2'd2,
        FATAL = 2'd3
    } state_t;

    state_t                  r_state;
    logic [tileIdWidth-1:0]  r_tile;
    logic                    r_interrupt;
    logic                    r_tile_ok;
    logic                    r_retry_req;
    logic                    r_fatal;
    logic [3:0]              r_syndrome;
    logic [counterWidth-1:0] r_err_count;
    logic [retryWidth-1:0]   r_attempt;
    logic                    r_busy;

    logic w_err;
    logic w_exhausted;
    logic w_cnt_full;

    assign w_err       = |bus.error;
    assign w_exhausted = (r_attempt >= retryWidth'(maxRetries));
    assign w_cnt_full  = &r_err_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_tile      <= '0;
            r_interrupt <= 1'b0;
            r_tile_ok   <= 1'b0;
            r_retry_req <= 1'b0;
            r_fatal     <= 1'b0;
            r_syndrome  <= '0;
            r_err_count <= '0;
            r_attempt   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_interrupt <= 1'b0;
            r_tile_ok   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_tile    <= bus.tile_id;
                        r_attempt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (bus.tile_done) begin
                        r_interrupt <= 1'b1;
                        if (!w_err) begin
                            r_tile_ok <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_syndrome <= bus.error;
                            if (!w_cnt_full)
                                r_err_count <= r_err_count + 1'b1;
                            if (w_exhausted) begin
                                r_fatal <= 1'b1;
                                r_state <= FATAL;
                            end else begin
                                r_retry_req <= 1'b1;
                                r_state     <= RETRY;
                            end
                        end
                    end
                end
                RETRY: begin
                    if (bus.retry_ack) begin
                        r_attempt   <= r_attempt + 1'b1;
                        r_retry_req <= 1'b0;
                        r_state     <= RUN;
                    end
                end
                FATAL: begin
                    if (bus.fatal_clear) begin
                        r_fatal   <= 1'b0;
                        r_attempt <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.interrupt    = r_interrupt;
    assign bus.tile_ok      = r_tile_ok;
    assign bus.retry_req    = r_retry_req;
    assign bus.retry_tile   = r_tile;
    assign bus.fatal        = r_fatal;
    assign bus.err_syndrome = r_syndrome;
    assign bus.err_count    = r_err_count;
    assign bus.attempt      = r_attempt;
    assign bus.busy         = r_busy;
endmodule

// File: tb/tb_labft_recovery_ctrl.sv
// Bench for labft_recovery_ctrl: directed vector table, async reset and
// saturation sequences, then random traffic against a behavioural model.
module tb_labft_recovery_ctrl;
    localparam int MR = 2;
    localparam int TW = 8;
    localparam int CW = 4;
    localparam int RW = $clog2(MR + 1);
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    labft_recovery_ctrl_if #(
        .maxRetries(MR), .tileIdWidth(TW), .counterWidth(CW)
    ) bus ();

    labft_recovery_ctrl #(
        .maxRetries(MR), .tileIdWidth(TW), .counterWidth(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic [TW-1:0] id,
                         input logic td, input logic [3:0] er,
                         input logic ack, input logic fc);
        bus.start       = st;
        bus.tile_id     = id;
        bus.tile_done   = td;
        bus.error       = er;
        bus.retry_ack   = ack;
        bus.fatal_clear = fc;
    endtask

    typedef struct {
        logic          st;
        logic [TW-1:0] id;
        logic          td;
        logic [3:0]    er;
        logic          ack;
        logic          fc;
        logic          xi;
        logic          ok;
        logic          rr;
        logic [TW-1:0] rt;
        logic          fat;
        logic          bsy;
        logic [CW-1:0] cnt;
        logic [RW-1:0] att;
        logic [3:0]    syn;
    } vec_t;

    function automatic vec_t v(
        input logic st, input logic [7:0] id, input logic td,
        input logic [3:0] er, input logic ack, input logic fc,
        input logic xi, input logic ok, input logic rr,
        input logic [7:0] rt, input logic fat, input logic bsy,
        input logic [3:0] cnt, input logic [1:0] att,
        input logic [3:0] syn);
        vec_t r;
        r.st = st; r.id = id; r.td = td; r.er = er; r.ack = ack; r.fc = fc;
        r.xi = xi; r.ok = ok; r.rr = rr; r.rt = rt; r.fat = fat;
        r.bsy = bsy; r.cnt = cnt; r.att = att; r.syn = syn;
        return r;
    endfunction

    // behavioural reference model
    typedef enum {M_IDLE, M_RUN, M_WAIT, M_DEAD} mmode_t;
    mmode_t        m_mode;
    logic [TW-1:0] m_id;
    int            m_tries;
    int            m_events;
    logic [3:0]    m_syn;
    logic          m_int;
    logic          m_ok;

    task automatic model_reset();
        m_mode = M_IDLE; m_id = '0; m_tries = 0; m_events = 0;
        m_syn = '0; m_int = 1'b0; m_ok = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic [TW-1:0] id,
                              input logic td, input logic [3:0] er,
                              input logic ack, input logic fc);
        m_int = 1'b0;
        m_ok  = 1'b0;
        case (m_mode)
            M_IDLE: if (st) begin
                m_id = id; m_tries = 0; m_mode = M_RUN;
            end
            M_RUN: if (td) begin
                m_int = 1'b1;
                if (er == 4'd0) begin
                    m_ok = 1'b1; m_mode = M_IDLE;
                end else begin
                    m_events++;
                    m_syn = er;
                    m_mode = (m_tries < MR) ? M_WAIT : M_DEAD;
                end
            end
            M_WAIT: if (ack) begin
                m_tries++; m_mode = M_RUN;
            end
            M_DEAD: if (fc) begin
                m_tries = 0; m_mode = M_IDLE;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic compare_model(input string tag);
        int cnt;
        cnt = (m_events > CNT_MAX) ? CNT_MAX : m_events;
        chk({tag, ".interrupt"}, 32'(bus.interrupt), 32'(m_int));
        chk({tag, ".tile_ok"}, 32'(bus.tile_ok), 32'(m_ok));
        chk({tag, ".retry_req"}, 32'(bus.retry_req), 32'(m_mode == M_WAIT));
        chk({tag, ".fatal"}, 32'(bus.fatal), 32'(m_mode == M_DEAD));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(m_mode != M_IDLE));
        chk({tag, ".err_count"}, 32'(bus.err_count), 32'(cnt));
        chk({tag, ".attempt"}, 32'(bus.attempt), 32'(m_tries));
        chk({tag, ".syndrome"}, 32'(bus.err_syndrome), 32'(m_syn));
        if (m_mode == M_WAIT)
            chk({tag, ".retry_tile"}, 32'(bus.retry_tile), 32'(m_id));
    endtask

    task automatic mstep(input string tag, input logic st,
                         input logic [TW-1:0] id, input logic td,
                         input logic [3:0] er, input logic ack,
                         input logic fc);
        drive(st, id, td, er, ack, fc);
        @(posedge clk);
        model_step(st, id, td, er, ack, fc);
        #1;
        compare_model(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".interrupt"}, 32'(bus.interrupt), 0);
        chk({tag, ".tile_ok"}, 32'(bus.tile_ok), 0);
        chk({tag, ".retry_req"}, 32'(bus.retry_req), 0);
        chk({tag, ".retry_tile"}, 32'(bus.retry_tile), 0);
        chk({tag, ".fatal"}, 32'(bus.fatal), 0);
        chk({tag, ".busy"}, 32'(bus.busy), 0);
        chk({tag, ".err_count"}, 32'(bus.err_count), 0);
        chk({tag, ".attempt"}, 32'(bus.attempt), 0);
        chk({tag, ".syndrome"}, 32'(bus.err_syndrome), 0);
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        // clean tile, single retry, exhaustion, ignored events
        tbl.push_back(v(1,8'h2A,0,4'h0,0,0, 0,0,0,8'h2A,0,1,0,0,4'h0));
        tbl.push_back(v(0,8'h00,1,4'h0,0,0, 1,1,0,8'h2A,0,0,0,0,4'h0));
        tbl.push_back(v(0,8'h00,0,4'h0,0,0, 0,0,0,8'h2A,0,0,0,0,4'h0));
        tbl.push_back(v(1,8'h2A,0,4'h0,0,0, 0,0,0,8'h2A,0,1,0,0,4'h0));
        tbl.push_back(v(0,8'h00,1,4'h4,0,0, 1,0,1,8'h2A,0,1,1,0,4'h4));
        tbl.push_back(v(0,8'h00,0,4'h0,0,0, 0,0,1,8'h2A,0,1,1,0,4'h4));
        tbl.push_back(v(0,8'h00,0,4'h0,0,0, 0,0,1,8'h2A,0,1,1,0,4'h4));
        tbl.push_back(v(0,8'h00,1,4'hF,0,0, 0,0,1,8'h2A,0,1,1,0,4'h4));
        tbl.push_back(v(0,8'h00,0,4'h0,0,0, 0,0,1,8'h2A,0,1,1,0,4'h4));
        tbl.push_back(v(0,8'h00,0,4'h0,0,0, 0,0,1,8'h2A,0,1,1,0,4'h4));
        tbl.push_back(v(0,8'h00,0,4'h0,1,0, 0,0,0,8'h2A,0,1,1,1,4'h4));
        tbl.push_back(v(0,8'h00,1,4'h0,0,0, 1,1,0,8'h2A,0,0,1,1,4'h4));
        tbl.push_back(v(0,8'h00,0,4'h0,1,0, 0,0,0,8'h2A,0,0,1,1,4'h4));
        tbl.push_back(v(1,8'h55,0,4'h0,0,0, 0,0,0,8'h55,0,1,1,0,4'h4));
        tbl.push_back(v(0,8'h00,1,4'h9,0,0, 1,0,1,8'h55,0,1,2,0,4'h9));
        tbl.push_back(v(0,8'h00,0,4'h0,1,0, 0,0,0,8'h55,0,1,2,1,4'h9));
        tbl.push_back(v(0,8'h00,1,4'h9,0,0, 1,0,1,8'h55,0,1,3,1,4'h9));
        tbl.push_back(v(0,8'h00,0,4'h0,1,0, 0,0,0,8'h55,0,1,3,2,4'h9));
        tbl.push_back(v(0,8'h00,1,4'h9,0,0, 1,0,0,8'h55,1,1,4,2,4'h9));
        tbl.push_back(v(1,8'h77,0,4'h0,0,0, 0,0,0,8'h55,1,1,4,2,4'h9));
        tbl.push_back(v(0,8'h00,1,4'h3,0,0, 0,0,0,8'h55,1,1,4,2,4'h9));
        tbl.push_back(v(0,8'h00,0,4'h0,0,1, 0,0,0,8'h55,0,0,4,0,4'h9));
        tbl.push_back(v(1,8'h11,1,4'h5,0,0, 0,0,0,8'h11,0,1,4,0,4'h9));
        tbl.push_back(v(0,8'h00,1,4'h0,0,0, 1,1,0,8'h11,0,0,4,0,4'h9));
        tbl.push_back(v(0,8'h00,1,4'h0,0,0, 0,0,0,8'h11,0,0,4,0,4'h9));

        foreach (tbl[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tbl[i].st, tbl[i].id, tbl[i].td, tbl[i].er,
                  tbl[i].ack, tbl[i].fc);
            @(posedge clk);
            #1;
            chk({t, ".interrupt"}, 32'(bus.interrupt), 32'(tbl[i].xi));
            chk({t, ".tile_ok"}, 32'(bus.tile_ok), 32'(tbl[i].ok));
            chk({t, ".retry_req"}, 32'(bus.retry_req), 32'(tbl[i].rr));
            chk({t, ".fatal"}, 32'(bus.fatal), 32'(tbl[i].fat));
            chk({t, ".busy"}, 32'(bus.busy), 32'(tbl[i].bsy));
            chk({t, ".err_count"}, 32'(bus.err_count), 32'(tbl[i].cnt));
            chk({t, ".attempt"}, 32'(bus.attempt), 32'(tbl[i].att));
            chk({t, ".syndrome"}, 32'(bus.err_syndrome), 32'(tbl[i].syn));
            if (tbl[i].rr)
                chk({t, ".retry_tile"}, 32'(bus.retry_tile), 32'(tbl[i].rt));
        end

        // asynchronous reset while a retry is pending
        rst = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
        mstep("ar_start", 1, 8'hC3, 0, 4'h0, 0, 0);
        mstep("ar_err", 0, 8'h00, 1, 4'h2, 0, 0);
        chk("ar_rr_before", 32'(bus.retry_req), 1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        mstep("ar_after", 0, 8'h00, 1, 4'h7, 1, 1);

        // saturation: 18 error events through repeated exhaustion
        for (int k = 0; k < 6; k++) begin
            mstep("sat", 1, 8'(k), 0, 4'h0, 0, 0);
            for (int r = 0; r < MR; r++) begin
                mstep("sat", 0, 8'h00, 1, 4'hA, 0, 0);
                mstep("sat", 0, 8'h00, 0, 4'h0, 1, 0);
            end
            mstep("sat", 0, 8'h00, 1, 4'hA, 0, 0);
            mstep("sat", 0, 8'h00, 0, 4'h0, 0, 1);
        end
        chk("sat_count", 32'(bus.err_count), CNT_MAX);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic st, td, ack, fc;
            logic [3:0] er;
            st  = ($urandom_range(0, 99) < 30);
            td  = ($urandom_range(0, 99) < 35);
            er  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            ack = ($urandom_range(0, 99) < 30);
            fc  = ($urandom_range(0, 99) < 20);
            mstep("rand", st, 8'($urandom), td, er, ack, fc);
            if (n == 1500) begin
                rst = 1'b0;
                #1;
                check_all_zero("rand_rst");
                rst = 1'b1;
                model_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
